// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns EX/MEM load/store fields into a req/ack access
// on a multi-cycle data memory, stalling the pipeline front until it completes.
//
// state  | meaning
// S_IDLE | examine EX/MEM fields; launch an access, flag an error, or pass through
// S_WAIT | request held on the memory bus until memAck or timeout
// S_DONE | one-cycle completion; captured data moves to MEM/WB
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] inResult,
    input  logic [31:0] inReadRegister2,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic [31:0] outResult,
    output logic [31:0] outReadData,
    output logic        outMemRead,
    output logic [2:0]  errFlags
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  waitCount;
    logic [31:0] capData;
    logic        oneReq;
    logic        aligned;
    logic        accept;

    assign oneReq  = inMemRead ^ inMemWrite;
    assign aligned = (inResult[1:0] == 2'b00);
    assign accept  = (state == S_IDLE) && oneReq && aligned;
    // Gated by reset_n so the pipeline is never frozen while reset is held.
    assign stall   = reset_n && (accept || (state == S_WAIT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            waitCount   <= 8'd0;
            capData     <= 32'd0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= 32'd0;
            memWdata    <= 32'd0;
            outResult   <= 32'd0;
            outReadData <= 32'd0;
            outMemRead  <= 1'b0;
            errFlags    <= 3'b000;
        end else begin
            if (!stall) begin
                outResult   <= inResult;
                outMemRead  <= inMemRead;
                outReadData <= (state == S_DONE) ? capData : 32'd0;
            end
            case (state)
                S_IDLE: begin
                    if (inMemRead && inMemWrite) begin
                        errFlags[2] <= 1'b1;
                    end else if (oneReq && !aligned) begin
                        errFlags[0] <= 1'b1;
                    end else if (oneReq) begin
                        memReq    <= 1'b1;
                        memWe     <= inMemWrite;
                        memAddr   <= {inResult[31:2], 2'b00};
                        memWdata  <= inReadRegister2;
                        waitCount <= 8'd0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (memAck) begin
                        capData <= memWe ? 32'd0 : memRdata;
                        memReq  <= 1'b0;
                        state   <= S_DONE;
                    end else if (waitCount == LAST_WAIT) begin
                        errFlags[1] <= 1'b1;
                        capData     <= 32'd0;
                        memReq      <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations, then
// randomized load/store traffic compared every cycle against a transaction model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] inResult, inReadRegister2, memRdata;
    logic        inMemRead, inMemWrite, memAck;
    logic        stall, memReq, memWe, outMemRead;
    logic [31:0] memAddr, memWdata, outResult, outReadData;
    logic [2:0]  errFlags;

    int checks = 0;
    int errors = 0;
    int stallCnt = 0;
    int reqCnt = 0;
    logic [15:0] reqHist = '0;
    bit lastStall = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .inResult(inResult), .inReadRegister2(inReadRegister2),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .stall(stall), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .outResult(outResult), .outReadData(outReadData),
        .outMemRead(outMemRead), .errFlags(errFlags)
    );

    // Transaction model: an outstanding access, how many WAIT cycles it has spent,
    // and whether this is its completion cycle.
    bit          mPending, mDone, mReq, mWe, mMr;
    int          mWaited;
    logic [31:0] mCap, mAddr, mWdata, mRes, mRd;
    logic [2:0]  mErr;

    function automatic bit modelStall();
        if (!reset_n) return 1'b0;
        if (mPending) return 1'b1;
        if (mDone) return 1'b0;
        return (inMemRead != inMemWrite) && (inResult[1:0] == 2'b00);
    endfunction

    task automatic modelReset();
        mPending = 0; mDone = 0; mReq = 0; mWe = 0; mMr = 0; mWaited = 0;
        mCap = 0; mAddr = 0; mWdata = 0; mRes = 0; mRd = 0; mErr = 0;
    endtask

    task automatic modelStep();
        bit st;
        bit fin;
        st = modelStall();
        fin = 0;
        if (!st) begin
            mRes = inResult;
            mMr  = inMemRead;
            mRd  = mDone ? mCap : 32'd0;
        end
        if (mDone) begin
            mDone = 0;
        end else if (mPending) begin
            mWaited++;
            if (memAck) begin
                mCap = mWe ? 32'd0 : memRdata;
                fin = 1;
            end else if (mWaited == TIMEOUT) begin
                mErr[1] = 1'b1;
                mCap = 32'd0;
                fin = 1;
            end
            if (fin) begin
                mPending = 0; mReq = 0; mDone = 1;
            end
        end else if (inMemRead && inMemWrite) begin
            mErr[2] = 1'b1;
        end else if (inMemRead || inMemWrite) begin
            if (inResult[1:0] != 2'b00) begin
                mErr[0] = 1'b1;
            end else begin
                mPending = 1; mWaited = 0; mReq = 1;
                mWe = inMemWrite; mAddr = inResult; mWdata = inReadRegister2;
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        check32("stall", 32'(stall), 32'(modelStall()));
        check32("memReq", 32'(memReq), 32'(mReq));
        check32("memWe", 32'(memWe), 32'(mWe));
        check32("memAddr", memAddr, mAddr);
        check32("memWdata", memWdata, mWdata);
        check32("outResult", outResult, mRes);
        check32("outReadData", outReadData, mRd);
        check32("outMemRead", 32'(outMemRead), 32'(mMr));
        check32("errFlags", 32'(errFlags), 32'(mErr));
    endtask

    task automatic cycle(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit ack, input logic [31:0] rdata);
        @(negedge clock);
        inMemRead = rd; inMemWrite = wr; inResult = addr;
        inReadRegister2 = data; memAck = ack; memRdata = rdata;
        #1;
        compareAll();
        lastStall = modelStall();
        if (stall) stallCnt++;
        if (memReq) reqCnt++;
        reqHist = {reqHist[14:0], memReq};
        @(posedge clock);
        modelStep();
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 0;
        inMemRead = 0; inMemWrite = 0; memAck = 0;
        inResult = 0; inReadRegister2 = 0; memRdata = 0;
        modelReset();
        #1 compareAll();
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        modelStep();
        stallCnt = 0; reqCnt = 0; reqHist = '0; lastStall = 0;
    endtask

    bit          curRd, curWr;
    logic [31:0] curAddr, curData;
    int          ackDelay, kind;
    bit          ack;

    initial begin
        reset_n = 1; inMemRead = 0; inMemWrite = 0; memAck = 0;
        inResult = 0; inReadRegister2 = 0; memRdata = 0;
        modelReset();

        // Load with ack in the first WAIT cycle.
        doReset();
        cycle(1, 0, 32'h100, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        #2 check32("zw_memAddr", memAddr, 32'h100);
        check32("zw_memWe", 32'(memWe), 32'd0);
        cycle(1, 0, 32'h100, 32'h0, 0, 32'h0);
        #2 check32("zw_outReadData", outReadData, 32'hDEADBEEF);
        check32("zw_outResult", outResult, 32'h100);
        check32("zw_outMemRead", 32'(outMemRead), 32'd1);
        check32("zw_stallCycles", 32'(stallCnt), 32'd2);

        // Store acked in the third WAIT cycle.
        doReset();
        cycle(0, 1, 32'h204, 32'h12345678, 0, 32'h0);
        cycle(0, 1, 32'h204, 32'h12345678, 0, 32'h0);
        cycle(0, 1, 32'h204, 32'h12345678, 0, 32'h0);
        cycle(0, 1, 32'h204, 32'h12345678, 1, 32'hFFFFFFFF);
        #2 check32("st_memWe", 32'(memWe), 32'd1);
        check32("st_memWdata", memWdata, 32'h12345678);
        cycle(0, 1, 32'h204, 32'h12345678, 0, 32'h0);
        #2 check32("st_reqCycles", 32'(reqCnt), 32'd3);
        check32("st_stallCycles", 32'(stallCnt), 32'd4);
        check32("st_outReadData", outReadData, 32'd0);
        check32("st_errFlags", 32'(errFlags), 32'd0);

        // Timeout: no ack at all.
        doReset();
        cycle(1, 0, 32'h10, 32'h0, 0, 32'h0);
        for (int i = 0; i < TIMEOUT + 1; i++) cycle(1, 0, 32'h10, 32'h0, 0, 32'h0);
        #2 check32("to_reqCycles", 32'(reqCnt), 32'd4);
        check32("to_stallCycles", 32'(stallCnt), 32'd5);
        check32("to_errFlags", 32'(errFlags), 32'b010);
        check32("to_outReadData", outReadData, 32'd0);
        check32("to_memReq", 32'(memReq), 32'd0);

        // Ack on the last permitted WAIT cycle counts as success.
        doReset();
        cycle(1, 0, 32'h20, 32'h0, 0, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1, 0, 32'h20, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h20, 32'h0, 1, 32'hCAFEF00D);
        cycle(1, 0, 32'h20, 32'h0, 0, 32'h0);
        #2 check32("edge_errFlags", 32'(errFlags), 32'd0);
        check32("edge_outReadData", outReadData, 32'hCAFEF00D);

        // Misaligned, then conflicting request.
        doReset();
        cycle(1, 0, 32'h102, 32'h0, 0, 32'h0);
        #2 check32("mis_errFlags", 32'(errFlags), 32'b001);
        check32("mis_memReq", 32'(memReq), 32'd0);
        cycle(1, 1, 32'h104, 32'h0, 0, 32'h0);
        #2 check32("cf_errFlags", 32'(errFlags), 32'b101);
        check32("cf_memReq", 32'(memReq), 32'd0);
        check32("cf_stallCycles", 32'(stallCnt), 32'd0);

        // Async reset during the second WAIT cycle.
        doReset();
        cycle(1, 0, 32'h40, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h40, 32'h0, 0, 32'h0);
        @(negedge clock);
        #1 check32("rst_preStall", 32'(stall), 32'd1);
        check32("rst_preReq", 32'(memReq), 32'd1);
        #1 reset_n = 0;
        #1 check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_memReq", 32'(memReq), 32'd0);
        check32("rst_memAddr", memAddr, 32'd0);
        check32("rst_memWdata", memWdata, 32'd0);
        check32("rst_outResult", outResult, 32'd0);
        check32("rst_outMemRead", 32'(outMemRead), 32'd0);
        check32("rst_errFlags", 32'(errFlags), 32'd0);
        modelReset();
        inMemRead = 0; inMemWrite = 0; inResult = 0; memAck = 0;
        #1 reset_n = 1;
        @(posedge clock);
        modelStep();
        lastStall = 0;
        cycle(0, 0, 32'h0, 32'h0, 1, 32'h55555555);
        #2 check32("stray_memReq", 32'(memReq), 32'd0);
        check32("stray_errFlags", 32'(errFlags), 32'd0);
        check32("stray_outReadData", outReadData, 32'd0);
        cycle(1, 0, 32'h80, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h80, 32'h0, 1, 32'h0BADF00D);
        cycle(1, 0, 32'h80, 32'h0, 0, 32'h0);
        #2 check32("fresh_outReadData", outReadData, 32'h0BADF00D);

        // Back-to-back loads.
        doReset();
        cycle(1, 0, 32'h0, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h0, 32'h0, 1, 32'hAAAA0001);
        cycle(1, 0, 32'h0, 32'h0, 0, 32'h0);
        #2 check32("b2b_first", outReadData, 32'hAAAA0001);
        cycle(1, 0, 32'h4, 32'h0, 0, 32'h0);
        cycle(1, 0, 32'h4, 32'h0, 1, 32'hBBBB0002);
        cycle(1, 0, 32'h4, 32'h0, 0, 32'h0);
        #2 check32("b2b_second", outReadData, 32'hBBBB0002);
        check32("b2b_outResult", outResult, 32'h4);
        cycle(0, 0, 32'h0, 32'h0, 0, 32'h0);
        check32("b2b_reqPattern", 32'(reqHist[6:0]), 32'(7'b0100100));

        // Randomized traffic, pipeline holds EX/MEM while stalled.
        curRd = 0; curWr = 0; curAddr = 0; curData = 0; ackDelay = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) doReset();
            if (!lastStall) begin
                kind = $urandom_range(0, 9);
                curAddr = $urandom() & 32'hFFFF_FFFC;
                curData = $urandom();
                ackDelay = $urandom_range(1, TIMEOUT + 1);
                curRd = (kind <= 3) || (kind == 7) || (kind == 9 && curData[0]);
                curWr = (kind >= 4 && kind <= 7) || (kind == 9 && !curData[0]);
                if (kind == 9) curAddr[1:0] = 2'($urandom_range(1, 3));
            end
            if (mPending) ack = (mWaited + 1 == ackDelay);
            else ack = ($urandom_range(0, 3) == 0);
            cycle(curRd, curWr, curAddr, curData, ack, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
